// File: rtl/rc_cmp_pkg.sv
// Shared types and helpers for the RC model equivalence sequencer.
package rc_cmp_pkg;

  localparam int DEF_WIDTH = 25;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Increment that sticks at maxVal instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] maxVal);
    return (val >= maxVal) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/rc_cmp_window_checker.sv
// Compares fast and slow model outputs on each compare strobe and keeps
// running statistics: a saturating mismatch count and the largest |diff|.
module rc_cmp_window_checker
  import rc_cmp_pkg::*;
#(
  parameter int          WIDTH = DEF_WIDTH,
  parameter int unsigned TOL   = 1,
  parameter int          CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             cmp_v_i,
  input  logic [WIDTH-1:0] v_fast_i,
  input  logic [WIDTH-1:0] v_slow_i,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [WIDTH:0]   max_abs_diff_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [WIDTH:0]   TolVal = (WIDTH+1)'(TOL);

  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   absDiff;
  logic [CNT_W-1:0] mismatchCnt_q, mismatchCnt_d;
  logic [WIDTH:0]   maxAbsDiff_q, maxAbsDiff_d;

  // One extra bit of headroom makes both the difference and its magnitude
  // exact, even for most-negative minus most-positive.
  always_comb begin
    diff    = {v_fast_i[WIDTH-1], v_fast_i} - {v_slow_i[WIDTH-1], v_slow_i};
    absDiff = diff[WIDTH] ? (~diff + 1'b1) : diff;
  end

  // Fold the current sample into the statistics only on a compare strobe.
  always_comb begin
    mismatchCnt_d = mismatchCnt_q;
    maxAbsDiff_d  = maxAbsDiff_q;
    if (clear_i) begin
      mismatchCnt_d = '0;
      maxAbsDiff_d  = '0;
    end else if (cmp_v_i) begin
      if (absDiff > TolVal) begin
        mismatchCnt_d = CNT_W'(sat_inc(32'(mismatchCnt_q), 32'(CntMax)));
      end
      if (absDiff > maxAbsDiff_q) begin
        maxAbsDiff_d = absDiff;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mismatchCnt_q <= '0;
      maxAbsDiff_q  <= '0;
    end else begin
      mismatchCnt_q <= mismatchCnt_d;
      maxAbsDiff_q  <= maxAbsDiff_d;
    end
  end

  assign mismatch_cnt_o = mismatchCnt_q;
  assign max_abs_diff_o = maxAbsDiff_q;

endmodule

// File: rtl/rc_cmp_sequencer.sv
// Drives a fast/slow RC model pair: holds them in reset, then enables the
// fast model every cycle and the slow model every RATIO cycles, comparing
// their outputs one cycle after each slow step once the settle window ends.
module rc_cmp_sequencer
  import rc_cmp_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int          RATIO     = 4,
  parameter int unsigned TOL       = 1,
  parameter int          SETTLE    = 8,
  parameter int          NUM_STEPS = 256,
  parameter int          RST_CYC   = 2,
  parameter int          CNT_W     = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             model_rst_o,
  output logic             fast_en_o,
  output logic             slow_en_o,
  input  logic [WIDTH-1:0] v_fast_i,
  input  logic [WIDTH-1:0] v_slow_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [WIDTH:0]   max_abs_diff_o
);

  localparam int PH_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int STEP_W = $clog2(NUM_STEPS + 1);
  localparam int RST_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_t            state_q, state_d;
  logic [RST_W-1:0]  rstCnt_q, rstCnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [STEP_W-1:0] stepCnt_q, stepCnt_d;
  logic              cmpV_q, cmpV_d;
  logic              lastCmp_q, lastCmp_d;
  logic              slowEn;
  logic              clearStats;

  // Next-state and Moore outputs; the final compare strobe is what ends RUN.
  always_comb begin
    state_d     = state_q;
    rstCnt_d    = rstCnt_q;
    phase_d     = phase_q;
    stepCnt_d   = stepCnt_q;
    cmpV_d      = 1'b0;
    lastCmp_d   = 1'b0;
    slowEn      = 1'b0;
    clearStats  = 1'b0;
    model_rst_o = 1'b1;
    fast_en_o   = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RESET;
          rstCnt_d = '0;
        end
      end
      RESET: begin
        busy_o     = 1'b1;
        clearStats = 1'b1;
        phase_d    = '0;
        stepCnt_d  = '0;
        if (rstCnt_q == RST_W'(RST_CYC - 1)) begin
          state_d  = RUN;
          rstCnt_d = '0;
        end else begin
          rstCnt_d = rstCnt_q + 1'b1;
        end
      end
      RUN: begin
        model_rst_o = 1'b0;
        busy_o      = 1'b1;
        fast_en_o   = 1'b1;
        slowEn      = (phase_q == PH_W'(RATIO - 1));
        phase_d     = slowEn ? '0 : phase_q + 1'b1;
        if (slowEn) begin
          stepCnt_d = stepCnt_q + 1'b1;
          cmpV_d    = (stepCnt_q >= STEP_W'(SETTLE));
          lastCmp_d = (stepCnt_q == STEP_W'(NUM_STEPS - 1));
        end
        if (lastCmp_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        model_rst_o = 1'b0;
        done_o      = 1'b1;
        if (start_i) begin
          state_d  = RESET;
          rstCnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the one-cycle-delayed compare strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rstCnt_q  <= '0;
      phase_q   <= '0;
      stepCnt_q <= '0;
      cmpV_q    <= 1'b0;
      lastCmp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rstCnt_q  <= rstCnt_d;
      phase_q   <= phase_d;
      stepCnt_q <= stepCnt_d;
      cmpV_q    <= cmpV_d;
      lastCmp_q <= lastCmp_d;
    end
  end

  assign slow_en_o = slowEn;
  assign pass_o    = done_o && (mismatch_cnt_o == '0);

  rc_cmp_window_checker #(
    .WIDTH (WIDTH),
    .TOL   (TOL),
    .CNT_W (CNT_W)
  ) u_checker (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (clearStats),
    .cmp_v_i        (cmpV_q),
    .v_fast_i       (v_fast_i),
    .v_slow_i       (v_slow_i),
    .mismatch_cnt_o (mismatch_cnt_o),
    .max_abs_diff_o (max_abs_diff_o)
  );

endmodule

// File: tb/tb_rc_cmp_sequencer.sv
// Self-checking bench for rc_cmp_sequencer: expected run results come from a
// small reference model, queued at start and compared when done rises.
`timescale 1ns/1ps
module tb_rc_cmp_sequencer;

  localparam int WIDTH     = 25;
  localparam int RATIO     = 4;
  localparam int TOL       = 1;
  localparam int SETTLE    = 4;
  localparam int NUM_STEPS = 16;
  localparam int RST_CYC   = 2;
  localparam int CNT_W     = 3;
  localparam int LATENCY   = RST_CYC + NUM_STEPS * RATIO + 2;
  localparam int FIRST_RUN = RST_CYC + 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int TIMEOUT   = LATENCY + 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             modelRst, fastEn, slowEn, busy, done, pass;
  logic [WIDTH-1:0] vFast = '0;
  logic [WIDTH-1:0] vSlow = '0;
  logic [CNT_W-1:0] mismatchCnt;
  logic [WIDTH:0]   maxAbsDiff;

  typedef struct {
    int     mm;
    longint maxd;
    bit     pass;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  int obsLatency, obsRstCycles, obsCadenceErr, obsSlowCount, obsHoldErr;

  always #5 clk = ~clk;

  rc_cmp_sequencer #(
    .WIDTH     (WIDTH),
    .RATIO     (RATIO),
    .TOL       (TOL),
    .SETTLE    (SETTLE),
    .NUM_STEPS (NUM_STEPS),
    .RST_CYC   (RST_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .model_rst_o    (modelRst),
    .fast_en_o      (fastEn),
    .slow_en_o      (slowEn),
    .v_fast_i       (vFast),
    .v_slow_i       (vSlow),
    .busy_o         (busy),
    .done_o         (done),
    .pass_o         (pass),
    .mismatch_cnt_o (mismatchCnt),
    .max_abs_diff_o (maxAbsDiff)
  );

  // Model output values presented for slow step k of pattern sel.
  function automatic void pattern(input int sel, input int k, output longint f, output longint s);
    case (sel)
      0: begin s = 64'd16 << 16; f = s; end
      1: begin s = 1000; f = s + (((k % 2) == 1) ? -1 : 1); end
      2: begin s = -5000; f = s + ((k >= SETTLE && k < SETTLE + 5) ? 2 : 0); end
      3: begin s = 777; f = s + ((k < SETTLE) ? 100 : 0); end
      4: begin f = -(64'sd1 << (WIDTH - 1)); s = (64'sd1 << (WIDTH - 1)) - 1; end
      default: begin s = 12345; f = s + ((k >= SETTLE && k < SETTLE + 10) ? 5 : 0); end
    endcase
  endfunction

  // Reference statistics over the compared steps of a full run.
  function automatic exp_t model(input int sel);
    exp_t   e;
    longint f, s, d;
    e.mm   = 0;
    e.maxd = 0;
    for (int k = SETTLE; k < NUM_STEPS; k++) begin
      pattern(sel, k, f, s);
      d = f - s;
      if (d < 0) d = -d;
      if (d > TOL && e.mm < CNT_MAX) e.mm++;
      if (d > e.maxd) e.maxd = d;
    end
    e.pass = (e.mm == 0);
    return e;
  endfunction

  // Runs one sequence from a start pulse, feeding model values per slow step
  // and recording timing observations; extraStartAt pulses start mid-run.
  task automatic applyStimulus(input int sel, input int extraStartAt);
    longint           f, s;
    bit               expFast, expSlow;
    logic [CNT_W-1:0] mmAtDone;
    logic [WIDTH:0]   maxAtDone;
    obsLatency    = -1;
    obsRstCycles  = 0;
    obsCadenceErr = 0;
    obsSlowCount  = 0;
    obsHoldErr    = 0;
    @(negedge clk);
    pattern(sel, 0, f, s);
    vFast = WIDTH'(f);
    vSlow = WIDTH'(s);
    start = 1'b1;
    expQ.push_back(model(sel));
    for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
      @(negedge clk);
      start = (cyc == extraStartAt);
      if (done) begin
        obsLatency = cyc;
        break;
      end
      if (modelRst && busy) obsRstCycles++;
      expFast = (cyc >= FIRST_RUN) && (cyc < LATENCY);
      expSlow = expFast && (((cyc - FIRST_RUN) % RATIO) == RATIO - 1);
      if (fastEn !== expFast || slowEn !== expSlow) obsCadenceErr++;
      if (slowEn === 1'b1) begin
        pattern(sel, obsSlowCount, f, s);
        vFast = WIDTH'(f);
        vSlow = WIDTH'(s);
        obsSlowCount++;
      end
    end
    start     = 1'b0;
    mmAtDone  = mismatchCnt;
    maxAtDone = maxAbsDiff;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b1 || busy !== 1'b0 || modelRst !== 1'b0 ||
          mismatchCnt !== mmAtDone || maxAbsDiff !== maxAtDone) obsHoldErr++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (modelRst !== 1'b1) begin errors++; $display("[TB] FAIL reset_model_rst: got %b expected 1", modelRst); end
    checks++; if (fastEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_fast_en: got %b expected 0", fastEn); end
    checks++; if (slowEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_slow_en: got %b expected 0", slowEn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass: got %b expected 0", pass); end
    checks++; if (mismatchCnt !== '0) begin errors++; $display("[TB] FAIL reset_mismatch: got %0d expected 0", mismatchCnt); end
    checks++; if (maxAbsDiff !== '0) begin errors++; $display("[TB] FAIL reset_max: got %0d expected 0", maxAbsDiff); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identical();
    exp_t e;
    applyStimulus(0, -1);
    e = expQ.pop_front();
    checks++; if (obsLatency != LATENCY) begin errors++; $display("[TB] FAIL ident_latency: got %0d expected %0d", obsLatency, LATENCY); end
    checks++; if (obsRstCycles != RST_CYC) begin errors++; $display("[TB] FAIL ident_rst_cycles: got %0d expected %0d", obsRstCycles, RST_CYC); end
    checks++; if (obsCadenceErr != 0) begin errors++; $display("[TB] FAIL ident_cadence: got %0d bad cycles expected 0", obsCadenceErr); end
    checks++; if (obsSlowCount != NUM_STEPS) begin errors++; $display("[TB] FAIL ident_slow_pulses: got %0d expected %0d", obsSlowCount, NUM_STEPS); end
    checks++; if (pass !== 1'(e.pass)) begin errors++; $display("[TB] FAIL ident_pass: got %b expected %b", pass, e.pass); end
    checks++; if (mismatchCnt !== CNT_W'(e.mm)) begin errors++; $display("[TB] FAIL ident_mismatch: got %0d expected %0d", mismatchCnt, e.mm); end
    checks++; if (maxAbsDiff !== (WIDTH+1)'(e.maxd)) begin errors++; $display("[TB] FAIL ident_max: got %0d expected %0d", maxAbsDiff, e.maxd); end
    checks++; if (obsHoldErr != 0) begin errors++; $display("[TB] FAIL ident_hold: got %0d unstable cycles expected 0", obsHoldErr); end
  endtask

  task automatic test_tol_edge();
    exp_t e;
    applyStimulus(1, -1);
    e = expQ.pop_front();
    checks++; if (obsLatency != LATENCY) begin errors++; $display("[TB] FAIL tol1_latency: got %0d expected %0d", obsLatency, LATENCY); end
    checks++; if (mismatchCnt !== CNT_W'(e.mm)) begin errors++; $display("[TB] FAIL tol1_mismatch: got %0d expected %0d", mismatchCnt, e.mm); end
    checks++; if (maxAbsDiff !== (WIDTH+1)'(e.maxd)) begin errors++; $display("[TB] FAIL tol1_max: got %0d expected %0d", maxAbsDiff, e.maxd); end
    checks++; if (pass !== 1'(e.pass)) begin errors++; $display("[TB] FAIL tol1_pass: got %b expected %b", pass, e.pass); end
  endtask

  task automatic test_tol_exceed();
    exp_t e;
    applyStimulus(2, 20);
    e = expQ.pop_front();
    checks++; if (obsLatency != LATENCY) begin errors++; $display("[TB] FAIL tol2_latency: got %0d expected %0d", obsLatency, LATENCY); end
    checks++; if (obsCadenceErr != 0) begin errors++; $display("[TB] FAIL tol2_cadence: got %0d bad cycles expected 0", obsCadenceErr); end
    checks++; if (mismatchCnt !== CNT_W'(e.mm)) begin errors++; $display("[TB] FAIL tol2_mismatch: got %0d expected %0d", mismatchCnt, e.mm); end
    checks++; if (maxAbsDiff !== (WIDTH+1)'(e.maxd)) begin errors++; $display("[TB] FAIL tol2_max: got %0d expected %0d", maxAbsDiff, e.maxd); end
    checks++; if (pass !== 1'(e.pass)) begin errors++; $display("[TB] FAIL tol2_pass: got %b expected %b", pass, e.pass); end
  endtask

  task automatic test_settle();
    exp_t e;
    applyStimulus(3, LATENCY - 1);
    e = expQ.pop_front();
    checks++; if (obsLatency != LATENCY) begin errors++; $display("[TB] FAIL settle_latency: got %0d expected %0d", obsLatency, LATENCY); end
    checks++; if (maxAbsDiff !== (WIDTH+1)'(e.maxd)) begin errors++; $display("[TB] FAIL settle_max: got %0d expected %0d", maxAbsDiff, e.maxd); end
    checks++; if (pass !== 1'(e.pass)) begin errors++; $display("[TB] FAIL settle_pass: got %b expected %b", pass, e.pass); end
    checks++; if (obsHoldErr != 0) begin errors++; $display("[TB] FAIL settle_final_start_hold: got %0d unstable cycles expected 0", obsHoldErr); end
  endtask

  task automatic test_extremes();
    exp_t e;
    applyStimulus(4, -1);
    e = expQ.pop_front();
    checks++; if (maxAbsDiff !== (WIDTH+1)'(e.maxd)) begin errors++; $display("[TB] FAIL extreme_max: got %0d expected %0d", maxAbsDiff, e.maxd); end
    checks++; if (mismatchCnt !== CNT_W'(e.mm)) begin errors++; $display("[TB] FAIL extreme_mismatch: got %0d expected %0d", mismatchCnt, e.mm); end
    checks++; if (pass !== 1'(e.pass)) begin errors++; $display("[TB] FAIL extreme_pass: got %b expected %b", pass, e.pass); end
    applyStimulus(5, -1);
    e = expQ.pop_front();
    checks++; if (obsRstCycles != RST_CYC) begin errors++; $display("[TB] FAIL sat_restart_rst_cycles: got %0d expected %0d", obsRstCycles, RST_CYC); end
    checks++; if (mismatchCnt !== CNT_W'(e.mm)) begin errors++; $display("[TB] FAIL sat_mismatch: got %0d expected %0d", mismatchCnt, e.mm); end
    checks++; if (maxAbsDiff !== (WIDTH+1)'(e.maxd)) begin errors++; $display("[TB] FAIL sat_max: got %0d expected %0d", maxAbsDiff, e.maxd); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    applyStimulus(0, -1);
    e = expQ.pop_front();
    checks++; if (obsRstCycles != RST_CYC) begin errors++; $display("[TB] FAIL b2b_rst_cycles: got %0d expected %0d", obsRstCycles, RST_CYC); end
    checks++; if (obsLatency != LATENCY) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", obsLatency, LATENCY); end
    checks++; if (mismatchCnt !== CNT_W'(e.mm)) begin errors++; $display("[TB] FAIL b2b_mismatch: got %0d expected %0d", mismatchCnt, e.mm); end
    checks++; if (maxAbsDiff !== (WIDTH+1)'(e.maxd)) begin errors++; $display("[TB] FAIL b2b_max: got %0d expected %0d", maxAbsDiff, e.maxd); end
    checks++; if (pass !== 1'(e.pass)) begin errors++; $display("[TB] FAIL b2b_pass: got %b expected %b", pass, e.pass); end
  endtask

  task automatic test_rst_midrun();
    longint f, s;
    pattern(4, 0, f, s);
    vFast = WIDTH'(f);
    vSlow = WIDTH'(s);
    start = 1'b1;
    repeat (40) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (mismatchCnt !== CNT_W'(5)) begin errors++; $display("[TB] FAIL midrun_pre_mismatch: got %0d expected 5", mismatchCnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrun_pre_busy: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (modelRst !== 1'b1) begin errors++; $display("[TB] FAIL midrun_model_rst: got %b expected 1", modelRst); end
    checks++; if (fastEn !== 1'b0 || slowEn !== 1'b0) begin errors++; $display("[TB] FAIL midrun_enables: got %b%b expected 00", fastEn, slowEn); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("[TB] FAIL midrun_flags: got %b%b%b expected 000", busy, done, pass); end
    checks++; if (mismatchCnt !== '0) begin errors++; $display("[TB] FAIL midrun_mismatch: got %0d expected 0", mismatchCnt); end
    checks++; if (maxAbsDiff !== '0) begin errors++; $display("[TB] FAIL midrun_max: got %0d expected 0", maxAbsDiff); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || modelRst !== 1'b1) begin errors++; $display("[TB] FAIL midrun_idle: got busy=%b model_rst=%b expected busy=0 model_rst=1", busy, modelRst); end
  endtask

  initial begin
    $display("[TB] rc_cmp_sequencer bench starting");
    test_reset();
    test_identical();
    test_tol_edge();
    test_tol_exceed();
    test_settle();
    test_extremes();
    test_back_to_back();
    test_rst_midrun();
    test_identical();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
